// File: rtl/pc_sequencer_if.sv
// Request/response bundle between the PC sequencer and its surrounding core logic.
// The master side drives redirect/trap/halt requests; the slave side (sequencer) returns PC state.
interface pc_sequencer_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 32
);

    logic              stall;
    logic              br_taken;
    logic [XLEN-1:0]   br_target;
    logic              trap_req;
    logic              mret;
    logic              halt_req;
    logic              resume;

    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   pc_plus4;
    logic [XLEN-1:0]   epc;
    logic              misaligned;
    logic [1:0]        state;
    logic [CNT_W-1:0]  adv_count;

    modport master (
        output stall,
        output br_taken,
        output br_target,
        output trap_req,
        output mret,
        output halt_req,
        output resume,
        input  pc,
        input  pc_plus4,
        input  epc,
        input  misaligned,
        input  state,
        input  adv_count
    );

    modport slave (
        input  stall,
        input  br_taken,
        input  br_target,
        input  trap_req,
        input  mret,
        input  halt_req,
        input  resume,
        output pc,
        output pc_plus4,
        output epc,
        output misaligned,
        output state,
        output adv_count
    );

endinterface

// File: rtl/pc_sequencer.sv
// Fetch program counter for the single-cycle RV32I core: reset vector, stall, redirect,
// trap entry/return, halt/resume, misaligned-target trapping and a retired-advance counter.
module pc_sequencer #(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100,
    parameter int unsigned     CNT_W        = 32
) (
    input  logic               clk,
    input  logic               reset,
    pc_sequencer_if.slave      bus
);

    typedef enum logic [1:0] {
        StBoot = 2'd0,
        StRun  = 2'd1,
        StHalt = 2'd2
    } state_e;

    localparam logic [XLEN-1:0]  PcStep = XLEN'(4);
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    state_e            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   epc_q, epc_d;
    logic              mis_q, mis_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [XLEN-1:0]   pc_seq;
    logic              br_misaligned;

    assign pc_seq        = pc_q + PcStep;
    assign br_misaligned = bus.br_taken && (bus.br_target[1:0] != 2'b00);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        epc_d   = epc_q;
        mis_d   = 1'b0;
        cnt_d   = cnt_q;

        unique case (state_q)
            // First cycle out of reset: requests are deliberately ignored.
            StBoot: begin
                state_d = StRun;
            end

            StRun: begin
                if (bus.trap_req) begin
                    epc_d = pc_q;
                    pc_d  = TRAP_VECTOR;
                end else if (bus.mret) begin
                    pc_d  = epc_q;
                    cnt_d = cnt_q + CntOne;
                end else if (br_misaligned) begin
                    mis_d = 1'b1;
                    epc_d = pc_q;
                    pc_d  = TRAP_VECTOR;
                end else if (bus.br_taken) begin
                    pc_d  = bus.br_target;
                    cnt_d = cnt_q + CntOne;
                end else if (bus.halt_req) begin
                    state_d = StHalt;
                end else if (!bus.stall) begin
                    pc_d  = pc_seq;
                    cnt_d = cnt_q + CntOne;
                end
            end

            // Only a trap or resume leaves HALT; resume takes effect without advancing pc.
            StHalt: begin
                if (bus.trap_req) begin
                    epc_d   = pc_q;
                    pc_d    = TRAP_VECTOR;
                    state_d = StRun;
                end else if (bus.resume) begin
                    state_d = StRun;
                end
            end

            default: begin
                state_d = StBoot;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StBoot;
            pc_q    <= RESET_VECTOR;
            epc_q   <= '0;
            mis_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            epc_q   <= epc_d;
            mis_q   <= mis_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.pc         = pc_q;
    assign bus.pc_plus4   = pc_seq;
    assign bus.epc        = epc_q;
    assign bus.misaligned = mis_q;
    assign bus.state      = state_q;
    assign bus.adv_count  = cnt_q;

endmodule
